// File: rtl/decoupled_va_pkg.sv
// Shared types and helpers for the decoupled valid/ack round-robin arbiter.
package decoupled_va_pkg;

  // Grant index width; a single requester still needs a 1-bit id port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/va_rr_picker.sv
// Combinational round-robin picker: scans upward from ptr, wrapping at NumReq-1.
module va_rr_picker
  import decoupled_va_pkg::*;
#(
  parameter int NumReq  = 4,
  parameter int IdWidth = id_width(NumReq)
) (
  input  logic [NumReq-1:0]  req,
  input  logic [IdWidth-1:0] ptr,
  output logic [NumReq-1:0]  grant,
  output logic [IdWidth-1:0] idx,
  output logic               any
);

  // First set request at or after the pointer wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      if (!any && req[(int'(ptr) + k) % NumReq]) begin
        any                                = 1'b1;
        grant[(int'(ptr) + k) % NumReq]    = 1'b1;
        idx                                = IdWidth'((int'(ptr) + k) % NumReq);
      end
    end
  end

endmodule

// File: rtl/decoupled_va_arbiter.sv
// Shares one downstream valid/ack channel among NumReq upstream masters.
// state | meaning
// IDLE  | no transfer in flight; arbitrate among in_valid each cycle
// BUSY  | granted payload registered on out_*; waiting for out_ack
module decoupled_va_arbiter
  import decoupled_va_pkg::*;
#(
  parameter int NumReq    = 4,
  parameter int DataWidth = 32,
  parameter int IdWidth   = id_width(NumReq)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NumReq-1:0]           in_valid,
  input  logic [NumReq*DataWidth-1:0] in_data,
  output logic [NumReq-1:0]           in_ack,
  output logic                        out_valid,
  output logic [DataWidth-1:0]        out_data,
  output logic [IdWidth-1:0]          out_id,
  input  logic                        out_ack
);

  state_t               state, state_next;
  logic [IdWidth-1:0]   ptr;
  logic [IdWidth-1:0]   ptr_wrap;
  logic [NumReq-1:0]    win_grant;
  logic [IdWidth-1:0]   win_idx;
  logic                 win_any;
  logic [DataWidth-1:0] win_data;

  va_rr_picker #(
    .NumReq (NumReq),
    .IdWidth(IdWidth)
  ) u_picker (
    .req  (in_valid),
    .ptr  (ptr),
    .grant(win_grant),
    .idx  (win_idx),
    .any  (win_any)
  );

  // One-hot AND-OR select of the winner's payload.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NumReq; i++) begin
      win_data = win_data | (in_data[i*DataWidth +: DataWidth] & {DataWidth{win_grant[i]}});
    end
  end

  // Pointer moves to the requester just after the one being served.
  always_comb begin
    ptr_wrap = (out_id == IdWidth'(NumReq - 1)) ? '0 : out_id + IdWidth'(1);
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_any) state_next = BUSY;
      BUSY:    if (out_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Grant capture into the output registers and pointer advance on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      ptr       <= '0;
    end else if (state == IDLE) begin
      if (win_any) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_id    <= win_idx;
      end
    end else if (out_ack) begin
      out_valid <= 1'b0;
      ptr       <= ptr_wrap;
    end
  end

  // Ack steering: only the granted requester sees the downstream ack, only in BUSY.
  always_comb begin
    in_ack = '0;
    if (state == BUSY) in_ack[out_id] = out_ack;
  end

`ifndef SYNTHESIS
  // Downstream payload held stable until acknowledged.
  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ack) |=> (out_valid && $stable(out_data) && $stable(out_id)));

  // Upstream acks are one-hot-or-zero.
  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ack));

  // An ack only goes to a requester that is presenting valid.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_ack_chk
    a_ack_valid: assert property (@(posedge clk) disable iff (!rst_n)
      in_ack[gi] |-> in_valid[gi]);
  end
`endif

endmodule
